// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program counter and instruction register stage. It drives the
//               instruction-memory address, latches and decodes the fetched
//               word, and selects the next PC from the PS/BC commands.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             PS,
    input  logic                   BC,
    input  logic                   IL,
    input  logic                   EOE,
    input  logic                   zero_flag,
    input  logic [PC_WIDTH-1:0]    jump_target,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [PC_WIDTH-1:0]    imem_addr,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [PC_WIDTH-1:0]    pc_next_seq,
    output logic [3:0]             opcode,
    output logic [3:0]             Rd,
    output logic [3:0]             Rs,
    output logic [3:0]             Rt,
    output logic [7:0]             imm,
    output logic                   halted,
    output logic [CNT_WIDTH-1:0]   instr_count
);

    localparam logic [1:0] c_PS_HOLD = 2'd0;
    localparam logic [1:0] c_PS_INC  = 2'd1;
    localparam logic [1:0] c_PS_REL  = 2'd2;
    localparam logic [1:0] c_PS_ABS  = 2'd3;
    localparam logic [3:0] c_OP_BIZ  = 4'd11;
    localparam logic [3:0] c_OP_BNZ  = 4'd12;

    logic [PC_WIDTH-1:0]    r_pc;
    logic [INSTR_WIDTH-1:0] r_ir;
    logic                   r_halted;
    logic [CNT_WIDTH-1:0]   r_instr_count;

    logic [PC_WIDTH-1:0]    w_pc_inc;
    logic [PC_WIDTH-1:0]    w_imm_ext;
    logic [PC_WIDTH-1:0]    w_pc_rel;
    logic                   w_is_cond_branch;
    logic                   w_branch_taken;
    logic [PC_WIDTH-1:0]    w_pc_next;

    assign w_pc_inc  = r_pc + PC_WIDTH'(1);
    assign w_imm_ext = PC_WIDTH'($signed(r_ir[7:0]));
    // pc already points past the branch, so the offset is relative to pc itself
    assign w_pc_rel  = r_pc + w_imm_ext;

    assign w_is_cond_branch = (r_ir[15:12] == c_OP_BIZ) || (r_ir[15:12] == c_OP_BNZ);
    assign w_branch_taken   = !w_is_cond_branch || (zero_flag == ~BC);

    always_comb begin
        w_pc_next = r_pc;
        case (PS)
            c_PS_HOLD: w_pc_next = r_pc;
            c_PS_INC:  w_pc_next = w_pc_inc;
            c_PS_REL:  w_pc_next = w_branch_taken ? w_pc_rel : w_pc_inc;
            c_PS_ABS:  w_pc_next = jump_target;
            default:   w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= '0;
            r_ir          <= '0;
            r_halted      <= 1'b0;
            r_instr_count <= '0;
        end else if (r_halted) begin
            r_pc          <= r_pc;
        end else if (EOE) begin
            r_halted      <= 1'b1;
        end else begin
            r_pc <= w_pc_next;
            if (IL) begin
                r_ir          <= imem_rdata;
                r_instr_count <= r_instr_count + CNT_WIDTH'(1);
            end
        end
    end

    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign pc_next_seq = w_pc_inc;
    assign opcode      = r_ir[15:12];
    assign Rd          = r_ir[11:8];
    assign Rs          = r_ir[7:4];
    assign Rt          = r_ir[3:0];
    assign imm         = r_ir[7:0];
    assign halted      = r_halted;
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed self-checking bench for pc_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  PS;
    logic        BC;
    logic        IL;
    logic        EOE;
    logic        zero_flag;
    logic [7:0]  jump_target;
    logic [15:0] imem_rdata;
    logic [7:0]  imem_addr;
    logic [7:0]  pc;
    logic [7:0]  pc_next_seq;
    logic [3:0]  opcode;
    logic [3:0]  Rd;
    logic [3:0]  Rs;
    logic [3:0]  Rt;
    logic [7:0]  imm;
    logic        halted;
    logic [15:0] instr_count;

    logic [15:0] imem [0:255];
    int checks = 0;
    int errors = 0;

    pc_fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .PS(PS), .BC(BC), .IL(IL), .EOE(EOE),
        .zero_flag(zero_flag), .jump_target(jump_target), .imem_rdata(imem_rdata),
        .imem_addr(imem_addr), .pc(pc), .pc_next_seq(pc_next_seq),
        .opcode(opcode), .Rd(Rd), .Rs(Rs), .Rt(Rt), .imm(imm),
        .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;
    assign imem_rdata = imem[imem_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        PS = 2'd0; BC = 1'b0; IL = 1'b0; EOE = 1'b0; zero_flag = 1'b0; jump_target = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        step(); step(); step();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
        imem[8'h00] = 16'hB0FC;
        imem[8'h10] = 16'hE305;
        imem[8'h15] = 16'hC002;

        do_reset();
        check("rst_pc", pc, 8'h00);
        check("rst_halted", halted, 1'b0);
        check("rst_cnt", instr_count, 16'd0);
        check("rst_opcode", opcode, 4'h0);
        check("rst_addr", imem_addr, 8'h00);
        check("rst_next_seq", pc_next_seq, 8'h01);

        // Fetch BIZ -4 and branch taken
        IL = 1'b1; PS = 2'd1; step();
        check("fetch_pc", pc, 8'h01);
        check("fetch_cnt", instr_count, 16'd1);
        check("fetch_opcode", opcode, 4'hB);
        check("fetch_Rd", Rd, 4'h0);
        check("fetch_Rs", Rs, 4'hF);
        check("fetch_Rt", Rt, 4'hC);
        check("fetch_imm", imm, 8'hFC);
        IL = 1'b0; PS = 2'd2; zero_flag = 1'b1; BC = 1'b0; step();
        check("biz_taken_pc", pc, 8'hFD);
        check("biz_taken_cnt", instr_count, 16'd1);

        // Same BIZ, zero_flag clear: falls through
        do_reset();
        IL = 1'b1; PS = 2'd1; step();
        IL = 1'b0; PS = 2'd2; zero_flag = 1'b0; BC = 1'b0; step();
        check("biz_not_taken_pc", pc, 8'h02);

        // BC=1, zero_flag=0: branch-if-nonzero taken
        do_reset();
        IL = 1'b1; PS = 2'd1; step();
        IL = 1'b0; PS = 2'd2; zero_flag = 1'b0; BC = 1'b1; step();
        check("bc1_taken_pc", pc, 8'hFD);

        // JMP +5 from 0x10 is unconditional
        do_reset();
        PS = 2'd3; jump_target = 8'h10; step();
        check("abs_pc_10", pc, 8'h10);
        PS = 2'd0; IL = 1'b1; step();
        check("jmp_load_opcode", opcode, 4'hE);
        check("jmp_load_Rd", Rd, 4'h3);
        check("jmp_hold_pc", pc, 8'h10);
        IL = 1'b0; PS = 2'd2; zero_flag = 1'b0; BC = 1'b0; step();
        check("jmp_pc", pc, 8'h15);

        // BNZ with BC=1, zero_flag=1: not taken
        IL = 1'b1; PS = 2'd1; step();
        check("bnz_load_opcode", opcode, 4'hC);
        check("bnz_load_pc", pc, 8'h16);
        IL = 1'b0; PS = 2'd2; zero_flag = 1'b1; BC = 1'b1; step();
        check("bnz_not_taken_pc", pc, 8'h17);
        check("cnt_two", instr_count, 16'd2);

        // PC wrap and absolute jump
        PS = 2'd3; jump_target = 8'hFF; step();
        check("pc_ff", pc, 8'hFF);
        check("next_seq_wrap", pc_next_seq, 8'h00);
        PS = 2'd1; step();
        check("pc_wrap", pc, 8'h00);
        PS = 2'd3; jump_target = 8'h42; step();
        check("abs_pc_42", pc, 8'h42);
        check("next_seq_43", pc_next_seq, 8'h43);
        check("addr_42", imem_addr, 8'h42);
        PS = 2'd0; step();
        check("hold_pc", pc, 8'h42);

        // EOE wins over PS/IL, then everything freezes
        EOE = 1'b1; PS = 2'd1; IL = 1'b1; step();
        check("eoe_halted", halted, 1'b1);
        check("eoe_pc", pc, 8'h42);
        check("eoe_cnt", instr_count, 16'd2);
        check("eoe_opcode", opcode, 4'hC);
        EOE = 1'b0; PS = 2'd3; jump_target = 8'h99;
        for (int i = 0; i < 10; i++) begin
            PS = (i % 2 == 0) ? 2'd3 : 2'd1;
            step();
            check("frozen_pc", pc, 8'h42);
            check("frozen_cnt", instr_count, 16'd2);
            check("frozen_opcode", opcode, 4'hC);
            check("frozen_halted", halted, 1'b1);
        end

        // Reset during a pending jump/load clears all state
        reset = 1'b1; PS = 2'd3; jump_target = 8'h77; IL = 1'b1; step();
        reset = 1'b0;
        idle();
        check("post_rst_pc", pc, 8'h00);
        check("post_rst_halted", halted, 1'b0);
        check("post_rst_cnt", instr_count, 16'd0);
        check("post_rst_opcode", opcode, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
